rsa_decrypt_core: RTL

RSA_DECRYPT_CORE -- requirements
Module: rsa_decrypt_core

---
 rtl/rsa_decrypt_core.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rsa_decrypt_core.sv
// rsa_decrypt_core
// ----------------
// Modular exponentiation plain = c^d mod n using bit-serial Montgomery
// multiplication with R = 2^WIDTH. All exponent bits take the same time.
// The multiply is always computed and only its commit depends on d_i.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      decrypt request, honoured in IDLE or DONE
//   stop       abort, honoured in every state, wins over start
//   cipher_in  ciphertext c
//   exp_in     private exponent d
//   mod_in     modulus n (must be odd and >= 3)
//   r2_in      R^2 mod n (must be < n)
//   plain_out  result, held until the next accepted start
//   busy       operation in progress
//   done       level, completion (valid or rejected)
//   error      level, last accepted start had invalid operands
//   state_dbg  current FSM state encoding
//
// Handshake: start is a request and is accepted when the FSM is idle or done
// and stop is low. The operands are latched on that edge. busy rises on the
// same edge. A result is valid while done=1 and error=0.
module rsa_decrypt_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cipher_in,
  input  logic [WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0] mod_in,
  input  logic [WIDTH-1:0] r2_in,
  output logic [WIDTH-1:0] plain_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PRE_X = 3'd2,
    PRE_A = 3'd3,
    MUL   = 3'd4,
    SQR   = 3'd5,
    POST  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] c_reg, d_reg, n_reg, r2_reg;
  logic [WIDTH-1:0] x_reg, acc_reg;
  logic [TW-1:0]    t_reg;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    bit_idx;

  logic [WIDTH-1:0] a_op, b_op, mm_res;
  logic [TW-1:0]    b_ext, n_ext, t_add, t_odd, t_iter;
  logic             a_bit, d_bit, last_cycle, in_mm, operands_bad;

  assign state_dbg = state;

  // Operand selection for the product running in the current state. acc and
  // x are only written on the final cycle of a product, so they stay stable
  // as operands for the whole product.
  always_comb begin
    a_op  = '0;
    b_op  = '0;
    in_mm = 1'b1;
    case (state)
      PRE_X:   begin a_op = c_reg;       b_op = r2_reg;      end
      PRE_A:   begin a_op = WIDTH'(1);   b_op = r2_reg;      end
      MUL:     begin a_op = acc_reg;     b_op = x_reg;       end
      SQR:     begin a_op = x_reg;       b_op = x_reg;       end
      POST:    begin a_op = acc_reg;     b_op = WIDTH'(1);   end
      default: in_mm = 1'b0;
    endcase
  end

  assign a_bit      = |(a_op & (WIDTH'(1) << cnt));
  assign d_bit      = |(d_reg & (WIDTH'(1) << bit_idx));
  assign last_cycle = (cnt == CW'(WIDTH));

  // One Montgomery iteration. With t < 2n and b < n the sum stays below 4n,
  // which fits in WIDTH+2 bits.
  assign b_ext  = {2'b00, b_op};
  assign n_ext  = {2'b00, n_reg};
  assign t_add  = t_reg + (a_bit ? b_ext : '0);
  assign t_odd  = t_add + (t_add[0] ? n_ext : '0);
  assign t_iter = t_odd >> 1;

  // Final conditional subtraction brings t from [0, 2n) into [0, n).
  assign mm_res = (t_reg >= n_ext) ? WIDTH'(t_reg - n_ext) : t_reg[WIDTH-1:0];

  assign operands_bad = ~n_reg[0] | (n_reg < WIDTH'(3)) | (r2_reg >= n_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_next = LOAD;
        LOAD:       state_next = operands_bad ? DONE : PRE_X;
        PRE_X:      if (last_cycle) state_next = PRE_A;
        PRE_A:      if (last_cycle) state_next = MUL;
        MUL:        if (last_cycle) state_next = SQR;
        SQR:        if (last_cycle)
                      state_next = (bit_idx == CW'(WIDTH - 1)) ? POST : MUL;
        POST:       if (last_cycle) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_reg     <= '0;
      d_reg     <= '0;
      n_reg     <= '0;
      r2_reg    <= '0;
      x_reg     <= '0;
      acc_reg   <= '0;
      t_reg     <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      plain_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else if (stop) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      t_reg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            c_reg  <= cipher_in;
            d_reg  <= exp_in;
            n_reg  <= mod_in;
            r2_reg <= r2_in;
            done   <= 1'b0;
            error  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          t_reg   <= '0;
          cnt     <= '0;
          bit_idx <= '0;
          if (operands_bad) begin
            error     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            plain_out <= '0;
          end
        end
        default: begin
          if (in_mm) begin
            if (last_cycle) begin
              t_reg <= '0;
              cnt   <= '0;
              case (state)
                PRE_X: x_reg   <= mm_res;
                PRE_A: acc_reg <= mm_res;
                MUL:   if (d_bit) acc_reg <= mm_res;
                SQR: begin
                  x_reg   <= mm_res;
                  bit_idx <= bit_idx + CW'(1);
                end
                POST: begin
                  plain_out <= mm_res;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                end
                default: ;
              endcase
            end else begin
              t_reg <= t_iter;
              cnt   <= cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
